// File: rtl/mult_seq_16bits.sv
// rtl/mult_seq_16bits.sv - sequential unsigned 16x16 shift-and-add multiplier with 32-bit held product
// One partial-product addition per cycle through a 16-bit ripple adder; start/busy/done handshake.

module full_adder_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [16:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[16];
endmodule

module mult_seq_16bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        hi_nz
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] mcand;
    logic [15:0] acc_hi;
    logic [15:0] acc_lo;
    logic [4:0]  cnt;
    logic        load;
    logic        step;
    logic        finish;

    logic [15:0] add_b;
    logic [15:0] sum;
    logic        cout;
    logic [15:0] next_hi;
    logic [15:0] next_lo;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign add_b = acc_lo[0] ? mcand : 16'h0000;

    full_adder_16bits u_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Carry-out becomes the new top bit, so the accumulator never overflows.
    assign next_hi = {cout, sum[15:1]};
    assign next_lo = {sum[0], acc_lo[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 5'd15) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= 16'h0000;
            acc_hi  <= 16'h0000;
            acc_lo  <= 16'h0000;
            cnt     <= 5'd0;
            product <= 32'h0000_0000;
            hi_nz   <= 1'b0;
        end else begin
            if (load) begin
                mcand  <= a;
                acc_lo <= b;
                acc_hi <= 16'h0000;
                cnt    <= 5'd0;
            end
            if (step) begin
                acc_hi <= next_hi;
                acc_lo <= next_lo;
                cnt    <= cnt + 5'd1;
            end
            // Product is only disturbed on completion; it holds the previous result meanwhile.
            if (finish) begin
                product <= {next_hi, next_lo};
                hi_nz   <= |next_hi;
            end
        end
    end
endmodule

// File: tb/tb_mult_seq_16bits.sv
// tb/tb_mult_seq_16bits.sv - scoreboard bench for mult_seq_16bits
module tb_mult_seq_16bits;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        hi_nz;

    int total;
    int bad;
    logic [32:0] exp_q[$];
    logic        done_prev;

    mult_seq_16bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expected result from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
            if (done && done_prev) chk("done_two_cycles", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("product", product, e[31:0]);
                    chk("hi_nz", {31'd0, hi_nz}, {31'd0, e[32]});
                end
            end
        end
        done_prev = rst_n && done;
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [15:0] ai, input logic [15:0] bi,
                         input logic [31:0] ep, input logic eh, input string name);
        int lat;
        @(negedge clk);
        start = 1'b1;
        a = ai;
        b = bi;
        exp_q.push_back({eh, ep});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk({name, "_latency"}, lat, 32'd16);
    endtask

    initial begin
        int lat;
        int gap;
        total = 0;
        bad = 0;
        done_prev = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_hi_nz", {31'd0, hi_nz}, 32'd0);
        rst_n = 1'b1;

        issue(16'h0003, 16'h0005, 32'h0000_000F, 1'b0, "3x5");
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, "ffxff");
        issue(16'h1234, 16'h0000, 32'h0000_0000, 1'b0, "bzero");
        issue(16'h0000, 16'hABCD, 32'h0000_0000, 1'b0, "azero");

        // Start held high: second op captures the operands changed during the first.
        @(negedge clk);
        start = 1'b1;
        a = 16'h0100;
        b = 16'h0100;
        exp_q.push_back({1'b1, 32'h0001_0000});
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 16'h0003;
        b = 16'h0005;
        wait_done(lat);
        chk("held_latency", lat + 3, 32'd16);
        exp_q.push_back({1'b0, 32'h0000_000F});
        gap = 0;
        @(posedge clk);
        gap++;
        @(negedge clk);
        while (!done && gap < 40) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
            if (gap == 2) start = 1'b0;
        end
        chk("held_period", gap, 32'd18);
        start = 1'b0;

        // Product holds the old result throughout a new computation.
        issue(16'h0002, 16'h0002, 32'h0000_0004, 1'b0, "2x2");
        @(negedge clk);
        start = 1'b1;
        a = 16'h8000;
        b = 16'h0002;
        exp_q.push_back({1'b1, 32'h0001_0000});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 1 || lat == 8 || lat == 15) begin
                chk("hold_product", product, 32'h0000_0004);
                chk("hold_hi_nz", {31'd0, hi_nz}, 32'd0);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("hold_latency", lat, 32'd16);

        // Reset mid-CALC aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_hi_nz", {31'd0, hi_nz}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, "ffx101");

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
